mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words stored; SHALL be a power of two, 2..65536.
REQ-002 Parameter WAIT, default 2, wait cycles inserted before completion; SHALL be 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 readMEM  input  1  read request from the initiator.
REQ-006 writeMEM  input  1  write request from the initiator.
REQ-007 addr  input  16  word address.
REQ-008 wdata  input  16  write data.
REQ-009 rdata  output  16  read data, registered.
REQ-010 data_oe  output  1  enable for the initiator-side tristate onto the data bus.
REQ-011 memDataReady  output  1  completion strobe, one cycle wide.
REQ-012 err  output  1  out-of-range strobe; present only under MEM_RESP_ERR_EN, otherwise tied 0.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 Requests SHALL be sampled only in IDLE; in IDLE, readMEM|writeMEM at a rising edge latches addr, wdata and op, loads wait counter with WAIT, and moves to BUSY (WAIT>0) or DONE (WAIT=0).
REQ-015 If readMEM and writeMEM are both high at acceptance, the write SHALL take priority and the read is dropped.
REQ-016 In BUSY the counter SHALL decrement once per cycle; on the edge where it equals 1 the state moves to DONE.
REQ-017 memDataReady SHALL be high for exactly the one DONE cycle, WAIT+1 cycles after the acceptance edge; DONE always returns to IDLE.
REQ-018 Read: rdata SHALL hold mem[addr_latched] and data_oe SHALL be 1 during the DONE cycle only; rdata holds its value afterwards, data_oe returns to 0.
REQ-019 Write: mem[addr_latched] SHALL be updated at the edge entering DONE; data_oe SHALL stay 0 for writes.
REQ-020 Address index SHALL be addr modulo DEPTH (low log2(DEPTH) bits) when MEM_RESP_ERR_EN is undefined.
REQ-021 Input changes on addr/wdata/readMEM/writeMEM during BUSY or DONE SHALL be ignored.
REQ-022 A request still high in the DONE cycle SHALL be accepted again from IDLE on the next edge (initiator drops requests on seeing memDataReady).
REQ-023 Back-to-back throughput SHALL be one transaction per WAIT+2 cycles.

Reset
REQ-024 rst low SHALL immediately force IDLE, counter 0, rdata 0x0000, data_oe 0, memDataReady 0, err 0.
REQ-025 Reset during BUSY SHALL abort the transaction; a pending write SHALL NOT modify memory.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro MEM_RESP_ERR_EN defined: addr >= DEPTH SHALL complete with normal timing, err=1 with memDataReady, no memory write, rdata=0x0000, data_oe=1 for reads.
REQ-028 Macro MEM_RESP_ERR_EN undefined: no range check, REQ-020 wrapping applies, err port tied 0.

Verification
REQ-029 WAIT=2: write addr 0x0010 data 0xBEEF, then read 0x0010 -> each memDataReady exactly 3 cycles after acceptance, rdata=0xBEEF, data_oe high one cycle.
REQ-030 WAIT=0: back-to-back writes to 0x0001=0x1234 and 0x0002=0x5678, reads back -> ready every 2nd cycle, correct data.
REQ-031 readMEM and writeMEM both high, addr 0x0005, wdata 0x00AA -> write performed, data_oe stays 0; subsequent read returns 0x00AA.
REQ-032 rst low one cycle mid-BUSY of write 0x0003=0xFFFF (prior 0x0001) -> outputs zero immediately, no ready, read of 0x0003 returns 0x0001.
REQ-033 DEPTH=256: write 0x0105=0xC0DE; without macro read 0x0005 returns 0xC0DE; with MEM_RESP_ERR_EN err=1, 0x0005 unchanged, rdata=0x0000.
REQ-034 readMEM held high across DONE -> second read accepted on the edge after DONE, two distinct ready strobes.

Source files
------------

// File: rtl/mem_responder.sv
//==============================================================================
// Module   : mem_responder
// Purpose  : Wait-state memory slave (IDLE/BUSY/DONE) with a one-cycle
//            completion strobe. Optional range check under MEM_RESP_ERR_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readMEM,
    input  logic        writeMEM,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        data_oe,
    output logic        memDataReady,
    output logic        err
);

    localparam int         c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_WAIT  = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [15:0]          r_wdata;
    logic                 r_op_wr;
    logic                 r_oor;
    logic [15:0]          r_rdata;
    logic                 r_oe;
    logic                 r_ready;
    logic [15:0]          r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_complete;
    logic [c_IDX_W-1:0]   w_idx;
    logic [15:0]          w_wdata;
    logic                 w_op_wr;
    logic                 w_addr_oor;
    logic                 w_oor;
    logic                 w_unused_addr;

    assign w_accept = (r_state == IDLE) && (readMEM || writeMEM);

    // With WAIT=0 completion coincides with acceptance, so the live request
    // fields are used on that edge instead of the (not yet loaded) latches.
    assign w_idx   = w_accept ? addr[c_IDX_W-1:0] : r_idx;
    assign w_wdata = w_accept ? wdata             : r_wdata;
    assign w_op_wr = w_accept ? writeMEM          : r_op_wr;
    assign w_oor   = w_accept ? w_addr_oor        : r_oor;

`ifdef MEM_RESP_ERR_EN
    assign w_addr_oor = ({1'b0, addr} >= 17'(DEPTH));
`else
    assign w_addr_oor = 1'b0;
`endif

    assign w_unused_addr = ^addr;
    assign w_complete    = (w_state_nxt == DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (c_WAIT == 4'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 16'h0000;
            r_op_wr <= 1'b0;
            r_oor   <= 1'b0;
            r_rdata <= 16'h0000;
            r_oe    <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= c_WAIT;
                r_idx   <= addr[c_IDX_W-1:0];
                r_wdata <= wdata;
                r_op_wr <= writeMEM;
                r_oor   <= w_addr_oor;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_ready <= w_complete;
            r_oe    <= w_complete && !w_op_wr;
            if (w_complete && !w_op_wr) begin
                r_rdata <= w_oor ? 16'h0000 : r_mem[w_idx];
            end
        end
    end

    // Storage has no reset; the rst qualifier keeps a write from landing on
    // an edge where reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && w_complete && w_op_wr && !w_oor) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_complete && w_oor;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign rdata        = r_rdata;
    assign data_oe      = r_oe;
    assign memDataReady = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//==============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench; instance 0 runs WAIT=2, 1 runs WAIT=0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_responder;

`ifdef MEM_RESP_ERR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] ad [2];
    logic [15:0] wd [2];
    logic [15:0] rdat [2];
    logic [1:0]  oe;
    logic [1:0]  rdy;
    logic [1:0]  er;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .readMEM(rd[0]), .writeMEM(wr[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rdat[0]), .data_oe(oe[0]),
        .memDataReady(rdy[0]), .err(er[0])
    );

    mem_responder #(.DEPTH(256), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .readMEM(rd[1]), .writeMEM(wr[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rdat[1]), .data_oe(oe[1]),
        .memDataReady(rdy[1]), .err(er[1])
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One isolated transaction; inputs are scrambled after acceptance.
    task automatic run_txn(input int u, input logic w, input logic r,
                           input logic [15:0] a, input logic [15:0] d,
                           input string tag, input logic [15:0] exp_rdata,
                           input logic exp_err);
        int          lat    = 0;
        int          nrdy   = 0;
        int          noe    = 0;
        int          oe_off = 0;
        logic [15:0] got    = 16'h0;
        logic        e      = 1'b0;
        bit          is_rd;
        is_rd = r && !w;
        @(negedge clk);
        rd[u] = r; wr[u] = w; ad[u] = a; wd[u] = d;
        @(posedge clk);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) begin
                rd[u] = 1'b0; wr[u] = 1'b0; ad[u] = ~a; wd[u] = ~d;
            end
            if (rdy[u]) begin
                nrdy++;
                if (lat == 0) begin
                    lat = j; got = rdat[u]; e = er[u];
                end
                if (oe[u]) noe++;
            end else if (oe[u]) begin
                oe_off++;
            end
        end
        check_val({tag, "_latency"}, 16'(lat), (u == 0) ? 16'd3 : 16'd1);
        check_val({tag, "_nready"}, 16'(nrdy), 16'd1);
        check_val({tag, "_oe_in_done"}, 16'(noe), is_rd ? 16'd1 : 16'd0);
        check_val({tag, "_oe_outside"}, 16'(oe_off), 16'd0);
        check_val({tag, "_err"}, {15'd0, e}, {15'd0, exp_err});
        if (is_rd) begin
            check_val({tag, "_rdata"}, got, exp_rdata);
            check_val({tag, "_rdata_hold"}, rdat[u], exp_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        int          second;
        int          cnt;
        int          idx;
        logic [15:0] pa [4];
        logic [15:0] pd [4];
        logic        pw [4];
        logic [15:0] pe [4];

        rst = 1'b1;
        rd = '0; wr = '0;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_rdata", rdat[0], 16'h0000);
        check_val("reset_ready", {14'd0, rdy}, 16'h0);
        check_val("reset_oe", {14'd0, oe}, 16'h0);
        check_val("reset_err", {14'd0, er}, 16'h0);
        check_val("reset_rdata_w0", rdat[1], 16'h0000);
        rst = 1'b1;

        run_txn(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, "w2_wr10", 16'h0, 1'b0);
        run_txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000, "w2_rd10", 16'hBEEF, 1'b0);

        run_txn(0, 1'b1, 1'b1, 16'h0005, 16'h00AA, "both_wr5", 16'h0, 1'b0);
        run_txn(0, 1'b0, 1'b1, 16'h0005, 16'h0000, "rd5", 16'h00AA, 1'b0);

        run_txn(0, 1'b1, 1'b0, 16'h0105, 16'hC0DE, "wr105", 16'h0, c_ERR_EN);
        run_txn(0, 1'b0, 1'b1, 16'h0005, 16'h0000, "rd5_alias",
                c_ERR_EN ? 16'h00AA : 16'hC0DE, 1'b0);
        run_txn(0, 1'b0, 1'b1, 16'h0105, 16'h0000, "rd105",
                c_ERR_EN ? 16'h0000 : 16'hC0DE, c_ERR_EN);

        // Read held through DONE: re-accepted once IDLE is reached.
        @(negedge clk);
        rd[0] = 1'b1; ad[0] = 16'h0010;
        first = 0; second = 0; cnt = 0;
        @(posedge clk);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (rdy[0]) begin
                cnt++;
                if (cnt == 1) first = j;
                else if (cnt == 2) begin
                    second = j; rd[0] = 1'b0;
                end
            end
        end
        rd[0] = 1'b0;
        check_val("held_rd_first", 16'(first), 16'd3);
        check_val("held_rd_second", 16'(second), 16'd7);
        check_val("held_rd_count", 16'(cnt), 16'd2);
        check_val("held_rd_rdata", rdat[0], 16'hBEEF);

        // Reset in the middle of a pending write.
        run_txn(0, 1'b1, 1'b0, 16'h0003, 16'h0001, "wr3", 16'h0, 1'b0);
        run_txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000, "rd10_pre_rst", 16'hBEEF, 1'b0);
        @(negedge clk);
        wr[0] = 1'b1; ad[0] = 16'h0003; wd[0] = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wr[0] = 1'b0;
        #1;
        check_val("rst_busy_rdata", rdat[0], 16'h0000);
        check_val("rst_busy_ready", {15'd0, rdy[0]}, 16'h0);
        check_val("rst_busy_oe", {15'd0, oe[0]}, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (rdy[0]) cnt++;
        end
        check_val("rst_no_ready", 16'(cnt), 16'd0);
        run_txn(0, 1'b0, 1'b1, 16'h0003, 16'h0000, "rd3_after_rst", 16'h0001, 1'b0);

        // WAIT=0 back-to-back: writes then reads, requests held continuously.
        pa = '{16'h0001, 16'h0002, 16'h0001, 16'h0002};
        pd = '{16'h1234, 16'h5678, 16'h0000, 16'h0000};
        pw = '{1'b1, 1'b1, 1'b0, 1'b0};
        pe = '{16'h0000, 16'h0000, 16'h1234, 16'h5678};
        @(negedge clk);
        wr[1] = pw[0]; rd[1] = !pw[0]; ad[1] = pa[0]; wd[1] = pd[0];
        idx = 0;
        @(posedge clk);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (rdy[1] && idx < 4) begin
                check_val($sformatf("b2b_slot%0d", idx), 16'(j), 16'(2 * idx + 1));
                if (!pw[idx]) check_val($sformatf("b2b_rdata%0d", idx), rdat[1], pe[idx]);
                idx++;
                if (idx < 4) begin
                    wr[1] = pw[idx]; rd[1] = !pw[idx]; ad[1] = pa[idx]; wd[1] = pd[idx];
                end else begin
                    wr[1] = 1'b0; rd[1] = 1'b0;
                end
            end
        end
        check_val("b2b_count", 16'(idx), 16'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
